// File: rtl/sram_pkg.sv
// Shared types and constants for the cache-side SRAM responder.
// Imported by sram_controller and sram_access_timer.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_e;

  localparam int SRAM_ADDR_W  = 18;
  localparam int SRAM_DATA_W  = 16;
  localparam int WR_HALFWORDS = 2;
  localparam int RD_HALFWORDS = 4;

endpackage

// File: rtl/sram_access_timer.sv
// Per-access wait counter: counts T = WAIT_CYCLES+1 cycles per halfword access.
// Ports: clk, rst, clear_i, run_i -> last_cycle_o, pre_last_o, access_done_o.
module sram_access_timer
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic last_cycle_o,
  output logic pre_last_o,
  output logic access_done_o
);

  localparam int T  = WAIT_CYCLES + 1;
  localparam int CW = $clog2(T + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_cycle_o  = (cnt_q == CW'(T - 1));
  // One cycle ahead of last_cycle_o so registered strobes can be timed.
  assign pre_last_o    = (cnt_q == CW'(T - 2));
  assign access_done_o = run_i && last_cycle_o;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !run_i) begin
      cnt_d = '0;
    end else if (last_cycle_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Cache-side responder: 32-bit word writes / 64-bit block reads over 16-bit async SRAM.
// Ports: clk, rst (async, active-high), rdEn, wrEn, address, writeData -> readData, ready;
// SRAM_DQ (inout), SRAM_ADDR, SRAM_WE_N, SRAM_OE_N/CE_N/UB_N/LB_N (tied low).
// Option: define SRAM_CTRL_LINE_BUF_EN for a one-entry read line buffer.
module sram_controller
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_ADDR_W = 18,
  parameter int SRAM_DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdEn,
  input  logic                   wrEn,
  input  logic [31:0]            address,
  input  logic [31:0]            writeData,
  output logic [63:0]            readData,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int AW = SRAM_ADDR_W;
  localparam int TW = SRAM_ADDR_W - 2;

  state_e             state_q;
  logic [AW-2:0]      a_q;
  logic [31:0]        wdata_q;
  logic [1:0]         hw_q;
  logic [AW-1:0]      sram_addr_q;
  logic [15:0]        dq_q;
  logic               drive_q;
  logic               we_n_q;
  logic [47:0]        rbuf_q;
  logic [63:0]        rdata_q;

  logic               last_cycle;
  logic               pre_last;
  logic               access_done;
  logic               t_run;
  logic               t_clear;
  logic               wr_start;
  logic               rd_fin;
  logic               lb_hit;
  logic [63:0]        lb_data;

  logic               unused_ok;
  assign unused_ok = ^{address[31:AW+1], address[1:0]};

  assign t_run   = (state_q == RD) || (state_q == WR);
  assign t_clear = (state_q == IDLE);

  sram_access_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (t_clear),
    .run_i        (t_run),
    .last_cycle_o (last_cycle),
    .pre_last_o   (pre_last),
    .access_done_o(access_done)
  );

  assign wr_start = (state_q == IDLE) && wrEn;
  assign rd_fin   = (state_q == RD) && access_done
                 && (hw_q == 2'(RD_HALFWORDS - 1));

`ifdef SRAM_CTRL_LINE_BUF_EN
  logic          lb_valid_q;
  logic [TW-1:0] lb_tag_q;
  logic [63:0]   lb_data_q;

  assign lb_hit  = lb_valid_q && (lb_tag_q == address[AW:3]);
  assign lb_data = lb_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_data_q  <= '0;
    end else if (wr_start) begin
      if (lb_tag_q == address[AW:3]) begin
        lb_valid_q <= 1'b0;
      end
    end else if (rd_fin) begin
      lb_valid_q <= 1'b1;
      lb_tag_q   <= a_q[AW-2:1];
      lb_data_q  <= {SRAM_DQ, rbuf_q};
    end
  end
`else
  assign lb_hit  = 1'b0;
  assign lb_data = '0;
`endif

  assign ready     = ((state_q == IDLE) && !rdEn && !wrEn)
                  || (state_q == DONE);
  assign readData  = rdata_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_DQ   = drive_q ? dq_q : 'z;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      wdata_q     <= '0;
      hw_q        <= '0;
      sram_addr_q <= '0;
      dq_q        <= '0;
      drive_q     <= 1'b0;
      we_n_q      <= 1'b1;
      rbuf_q      <= '0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wrEn) begin
            state_q     <= WR;
            a_q         <= address[AW:2];
            wdata_q     <= writeData;
            hw_q        <= '0;
            sram_addr_q <= {address[AW:2], 1'b0};
            dq_q        <= writeData[15:0];
            drive_q     <= 1'b1;
            we_n_q      <= 1'b0;
          end else if (rdEn && lb_hit) begin
            state_q <= DONE;
            rdata_q <= lb_data;
          end else if (rdEn) begin
            state_q     <= RD;
            a_q         <= address[AW:2];
            hw_q        <= '0;
            sram_addr_q <= {address[AW:3], 2'b00};
            drive_q     <= 1'b0;
            we_n_q      <= 1'b1;
          end
        end
        WR: begin
          if (access_done) begin
            if (hw_q == 2'(WR_HALFWORDS - 1)) begin
              state_q <= DONE;
              drive_q <= 1'b0;
              we_n_q  <= 1'b1;
            end else begin
              hw_q        <= hw_q + 2'd1;
              sram_addr_q <= {a_q, 1'b1};
              dq_q        <= wdata_q[31:16];
              we_n_q      <= 1'b0;
            end
          end else if (pre_last) begin
            // Release WE one cycle early so address/data hold past the strobe.
            we_n_q <= 1'b1;
          end
        end
        RD: begin
          if (last_cycle) begin
            if (hw_q == 2'(RD_HALFWORDS - 1)) begin
              state_q <= DONE;
              rdata_q <= {SRAM_DQ, rbuf_q};
            end else begin
              rbuf_q[16*hw_q +: 16] <= SRAM_DQ;
              hw_q                  <= hw_q + 2'd1;
              sram_addr_q           <= {a_q[AW-2:1], hw_q + 2'd1};
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural async SRAM.
// Optionally built with SRAM_CTRL_LINE_BUF_EN to exercise the line buffer.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        rdEn;
  logic        wrEn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [63:0] readData;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;
  logic        SRAM_CE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;

  int n_chk;
  int n_fail;
  int we_lo;
  logic rd_phase;
  logic [15:0] mem [0:1023];

  sram_controller #(
    .WAIT_CYCLES(1),
    .SRAM_ADDR_W(18),
    .SRAM_DATA_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdEn     (rdEn),
    .wrEn     (wrEn),
    .address  (address),
    .writeData(writeData),
    .readData (readData),
    .ready    (ready),
    .SRAM_DQ  (SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N),
    .SRAM_CE_N(SRAM_CE_N),
    .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives the bus only while a read is outstanding.
  assign SRAM_DQ = rd_phase ? mem[SRAM_ADDR[9:0]] : 'z;

  always @(posedge clk) begin
    if (!SRAM_WE_N) mem[SRAM_ADDR[9:0]] <= SRAM_DQ;
  end

  always @(negedge clk) begin
    if (!SRAM_WE_N) we_lo = we_lo + 1;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic dq_free();
    return (SRAM_DQ === 16'hzzzz) || (SRAM_DQ === 16'h0000);
  endfunction

  task automatic xact(input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int lat);
    @(posedge clk);
    #1;
    rdEn      = rd;
    wrEn      = wr;
    address   = a;
    writeData = wd;
    rd_phase  = rd && !wr;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    rdEn     = 1'b0;
    wrEn     = 1'b0;
    rd_phase = 1'b0;
  endtask

  int lat;
  int hit_lat;
  logic [17:0] a_before;
  logic [63:0] held;

  initial begin
    n_chk = 0;
    n_fail = 0;
    we_lo = 0;
    rd_phase = 1'b0;
    rdEn = 1'b0;
    wrEn = 1'b0;
    address = '0;
    writeData = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h200] = 16'h1111;
    mem[10'h201] = 16'h2222;
`ifdef SRAM_CTRL_LINE_BUF_EN
    hit_lat = 1;
`else
    hit_lat = 9;
`endif

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(ready), 64'd1);
    check("idle_we_n", 64'(SRAM_WE_N), 64'd1);
    check("idle_dq_z", 64'(dq_free()), 64'd1);
    check("idle_rdata", readData, 64'h0);

    we_lo = 0;
    xact(1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, lat);
    check("wr_lat", 64'(lat), 64'd5);
    check("wr_we_pulses", 64'(we_lo), 64'd2);
    check("wr_mem202", 64'(mem[10'h202]), 64'hBEEF);
    check("wr_mem203", 64'(mem[10'h203]), 64'hDEAD);

    we_lo = 0;
    xact(1'b1, 1'b0, 32'h0000_0400, 32'h0, lat);
    check("rd_lat", 64'(lat), 64'd9);
    check("rd_data", readData, 64'hDEADBEEF_22221111);
    check("rd_no_we", 64'(we_lo), 64'd0);

    we_lo = 0;
    xact(1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_5A5A, lat);
    check("sim_lat", 64'(lat), 64'd5);
    check("sim_mem004", 64'(mem[10'h004]), 64'h5A5A);
    check("sim_mem005", 64'(mem[10'h005]), 64'hA5A5);
    check("sim_rdata_held", readData, 64'hDEADBEEF_22221111);
    check("sim_we_pulses", 64'(we_lo), 64'd2);

    xact(1'b1, 1'b0, 32'h0000_0008, 32'h0, lat);
    check("rd8_lat", 64'(lat), 64'd9);
    check("rd8_data", readData, 64'h00000000_A5A55A5A);

    @(posedge clk);
    #1;
    rdEn = 1'b1;
    address = 32'h0000_0400;
    rd_phase = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    rdEn = 1'b0;
    rd_phase = 1'b0;
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_rdata", readData, 64'h0);
    check("rst_we_n", 64'(SRAM_WE_N), 64'd1);
    check("rst_dq_z", 64'(dq_free()), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    xact(1'b1, 1'b0, 32'h0000_0400, 32'h0, lat);
    check("post_rst_lat", 64'(lat), 64'd9);
    check("post_rst_data", readData, 64'hDEADBEEF_22221111);

    a_before = SRAM_ADDR;
    xact(1'b1, 1'b0, 32'h0000_0400, 32'h0, lat);
    check("lb1_lat", 64'(lat), 64'(hit_lat));
    check("lb1_data", readData, 64'hDEADBEEF_22221111);
    check("lb1_addr_idle", 64'(SRAM_ADDR), 64'(a_before));

    xact(1'b1, 1'b0, 32'h0000_0404, 32'h0, lat);
    check("lb2_lat", 64'(lat), 64'(hit_lat));
    check("lb2_data", readData, 64'hDEADBEEF_22221111);

    xact(1'b0, 1'b1, 32'h0000_0404, 32'h1234_5678, lat);
    check("lbw_lat", 64'(lat), 64'd5);
    held = readData;
    check("lbw_rdata_held", held, 64'hDEADBEEF_22221111);

    xact(1'b1, 1'b0, 32'h0000_0400, 32'h0, lat);
    check("lb3_lat", 64'(lat), 64'd9);
    check("lb3_data", readData, 64'h12345678_22221111);

    @(negedge clk);
    check("end_ready", 64'(ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
